mmss_timer: RTL and testbench

- Parametrised minutes:seconds timekeeping core.
- Counts up or down on a qualified tick, and supports start/stop, preset load, and wrap or terminal-stop mode.
- Sits between the tick prescaler and the display/alarm logic. It is the generalised successor to the fixed 00:00–59:59 up-counter.

---
 rtl/mmss_timer.sv | 142 ++++++++++++++
 tb/tb_mmss_timer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmss_timer.sv
// rtl/mmss_timer.sv - parametrised minutes:seconds up/down timer with start/stop, preset load and wrap/terminal modes
module mmss_timer #(
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59,
    parameter int SEC_W   = 6,
    parameter int MIN_W   = 6,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_tick,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_dir,
    input  logic             i_load,
    input  logic [MIN_W-1:0] i_load_min,
    input  logic [SEC_W-1:0] i_load_sec,
    output logic [MIN_W-1:0] o_minutes,
    output logic [SEC_W-1:0] o_seconds,
    output logic             o_running,
    output logic             o_done,
    output logic             o_min_carry,
    output logic             o_wrap_p
);

    localparam logic [SEC_W-1:0] SEC_TOP = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    logic [MIN_W-1:0] r_min;
    logic [SEC_W-1:0] r_sec;
    logic             r_running;
    logic             r_done;
    logic             r_carry;
    logic             r_wrap;

    state_t           w_state_nxt;
    logic [MIN_W-1:0] w_min_nxt;
    logic [SEC_W-1:0] w_sec_nxt;
    logic             w_carry_nxt;
    logic             w_wrap_nxt;
    logic             w_at_zero;

    assign w_at_zero = (r_min == '0) && (r_sec == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_STOPPED;
            r_min     <= '0;
            r_sec     <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_carry   <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_min     <= w_min_nxt;
            r_sec     <= w_sec_nxt;
            r_running <= (w_state_nxt == ST_RUNNING);
            r_done    <= (w_state_nxt == ST_DONE);
            r_carry   <= w_carry_nxt;
            r_wrap    <= w_wrap_nxt;
        end
    end

    // Control inputs are mutually prioritised; a step only happens when none of them is active.
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_carry_nxt = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (i_load) begin
            w_min_nxt = (i_load_min > MIN_TOP) ? MIN_TOP : i_load_min;
            w_sec_nxt = (i_load_sec > SEC_TOP) ? SEC_TOP : i_load_sec;
            if (r_state == ST_DONE) begin
                w_state_nxt = ST_STOPPED;
            end
        end else if (i_stop) begin
            if (r_state == ST_RUNNING) begin
                w_state_nxt = ST_STOPPED;
            end
        end else if (i_start) begin
            if (r_state != ST_RUNNING) begin
                if (i_dir && w_at_zero && (WRAP == 0)) begin
                    w_state_nxt = ST_DONE;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_RUNNING;
                end
            end
        end else if ((r_state == ST_RUNNING) && i_tick) begin
            if (!i_dir) begin
                if (r_sec < SEC_TOP) begin
                    w_sec_nxt = r_sec + SEC_W'(1);
                end else if (r_min < MIN_TOP) begin
                    w_sec_nxt   = '0;
                    w_min_nxt   = r_min + MIN_W'(1);
                    w_carry_nxt = 1'b1;
                end else if (WRAP != 0) begin
                    w_sec_nxt   = '0;
                    w_min_nxt   = '0;
                    w_carry_nxt = 1'b1;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_wrap_nxt  = 1'b1;
                end
            end else begin
                if (r_sec != '0) begin
                    w_sec_nxt = r_sec - SEC_W'(1);
                end else if (r_min != '0) begin
                    w_sec_nxt   = SEC_TOP;
                    w_min_nxt   = r_min - MIN_W'(1);
                    w_carry_nxt = 1'b1;
                end else if (WRAP != 0) begin
                    w_sec_nxt   = SEC_TOP;
                    w_min_nxt   = MIN_TOP;
                    w_carry_nxt = 1'b1;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_wrap_nxt  = 1'b1;
                end
            end
        end
    end

    assign o_minutes   = r_min;
    assign o_seconds   = r_sec;
    assign o_running   = r_running;
    assign o_done      = r_done;
    assign o_min_carry = r_carry;
    assign o_wrap_p    = r_wrap;

endmodule

// File: tb/tb_mmss_timer.sv
// tb/tb_mmss_timer.sv - four parameterisations of mmss_timer checked against a linear-time reference model
module tb_mmss_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_min = '0;
    logic [5:0] load_sec = '0;
    logic [2:0] load_min_s;
    logic [3:0] load_sec_s;

    assign load_min_s = load_min[2:0];
    assign load_sec_s = load_sec[3:0];

    logic [5:0] min0, sec0, min1, sec1;
    logic [2:0] min2, min3;
    logic [3:0] sec2, sec3;
    logic run0, done0, cy0, wp0, run1, done1, cy1, wp1;
    logic run2, done2, cy2, wp2, run3, done3, cy3, wp3;

    always #5 clk = ~clk;

    mmss_timer #(.SEC_MAX(59), .MIN_MAX(59), .SEC_W(6), .MIN_W(6), .WRAP(1)) u0 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_start(start), .i_stop(stop), .i_dir(dir),
        .i_load(load), .i_load_min(load_min), .i_load_sec(load_sec),
        .o_minutes(min0), .o_seconds(sec0), .o_running(run0), .o_done(done0),
        .o_min_carry(cy0), .o_wrap_p(wp0));

    mmss_timer #(.SEC_MAX(59), .MIN_MAX(59), .SEC_W(6), .MIN_W(6), .WRAP(0)) u1 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_start(start), .i_stop(stop), .i_dir(dir),
        .i_load(load), .i_load_min(load_min), .i_load_sec(load_sec),
        .o_minutes(min1), .o_seconds(sec1), .o_running(run1), .o_done(done1),
        .o_min_carry(cy1), .o_wrap_p(wp1));

    mmss_timer #(.SEC_MAX(9), .MIN_MAX(3), .SEC_W(4), .MIN_W(3), .WRAP(1)) u2 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_start(start), .i_stop(stop), .i_dir(dir),
        .i_load(load), .i_load_min(load_min_s), .i_load_sec(load_sec_s),
        .o_minutes(min2), .o_seconds(sec2), .o_running(run2), .o_done(done2),
        .o_min_carry(cy2), .o_wrap_p(wp2));

    mmss_timer #(.SEC_MAX(9), .MIN_MAX(3), .SEC_W(4), .MIN_W(3), .WRAP(0)) u3 (
        .clk(clk), .rst(rst), .i_tick(tick), .i_start(start), .i_stop(stop), .i_dir(dir),
        .i_load(load), .i_load_min(load_min_s), .i_load_sec(load_sec_s),
        .o_minutes(min3), .o_seconds(sec3), .o_running(run3), .o_done(done3),
        .o_min_carry(cy3), .o_wrap_p(wp3));

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state per instance; time is held as elapsed seconds within one full cycle.
    int P_SMAX [4] = '{59, 59, 9, 9};
    int P_MMAX [4] = '{59, 59, 3, 3};
    int P_WRAP [4] = '{1, 0, 1, 0};
    int m_t    [4];
    int m_st   [4];   // 0 stopped, 1 running, 2 done
    int m_cy   [4];
    int m_wp   [4];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic get_obs(input int k, output int mn, output int sc, output int rn,
                           output int dn, output int cy, output int wp);
        case (k)
            0: begin mn = int'(min0); sc = int'(sec0); rn = int'(run0); dn = int'(done0); cy = int'(cy0); wp = int'(wp0); end
            1: begin mn = int'(min1); sc = int'(sec1); rn = int'(run1); dn = int'(done1); cy = int'(cy1); wp = int'(wp1); end
            2: begin mn = int'(min2); sc = int'(sec2); rn = int'(run2); dn = int'(done2); cy = int'(cy2); wp = int'(wp2); end
            default: begin mn = int'(min3); sc = int'(sec3); rn = int'(run3); dn = int'(done3); cy = int'(cy3); wp = int'(wp3); end
        endcase
    endtask

    task automatic model_step(input bit r, input bit ld, input bit sp, input bit st,
                              input bit tk, input bit d, input int lm, input int ls);
        for (int k = 0; k < 4; k++) begin
            int per, full, mn, sc;
            per  = P_SMAX[k] + 1;
            full = (P_MMAX[k] + 1) * per;
            m_cy[k] = 0;
            m_wp[k] = 0;
            if (r) begin
                m_t[k]  = 0;
                m_st[k] = 0;
            end else if (ld) begin
                mn = (k < 2) ? (lm & 63) : (lm & 7);
                sc = (k < 2) ? (ls & 63) : (ls & 15);
                if (mn > P_MMAX[k]) mn = P_MMAX[k];
                if (sc > P_SMAX[k]) sc = P_SMAX[k];
                m_t[k] = mn * per + sc;
                if (m_st[k] == 2) m_st[k] = 0;
            end else if (sp) begin
                if (m_st[k] == 1) m_st[k] = 0;
            end else if (st) begin
                if (m_st[k] != 1) begin
                    if (d && m_t[k] == 0 && P_WRAP[k] == 0) begin
                        m_st[k] = 2;
                        m_wp[k] = 1;
                    end else begin
                        m_st[k] = 1;
                    end
                end
            end else if (m_st[k] == 1 && tk) begin
                if (!d) begin
                    if (m_t[k] == full - 1) begin
                        m_wp[k] = 1;
                        if (P_WRAP[k] != 0) begin m_t[k] = 0; m_cy[k] = 1; end
                        else m_st[k] = 2;
                    end else begin
                        m_cy[k] = (m_t[k] % per == P_SMAX[k]) ? 1 : 0;
                        m_t[k]  = m_t[k] + 1;
                    end
                end else begin
                    if (m_t[k] == 0) begin
                        m_wp[k] = 1;
                        if (P_WRAP[k] != 0) begin m_t[k] = full - 1; m_cy[k] = 1; end
                        else m_st[k] = 2;
                    end else begin
                        m_cy[k] = (m_t[k] % per == 0) ? 1 : 0;
                        m_t[k]  = m_t[k] - 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        int mn, sc, rn, dn, cy, wp;
        for (int k = 0; k < 4; k++) begin
            get_obs(k, mn, sc, rn, dn, cy, wp);
            chk($sformatf("u%0d.minutes", k), mn, m_t[k] / (P_SMAX[k] + 1));
            chk($sformatf("u%0d.seconds", k), sc, m_t[k] % (P_SMAX[k] + 1));
            chk($sformatf("u%0d.running", k), rn, (m_st[k] == 1) ? 1 : 0);
            chk($sformatf("u%0d.done", k), dn, (m_st[k] == 2) ? 1 : 0);
            chk($sformatf("u%0d.min_carry", k), cy, m_cy[k]);
            chk($sformatf("u%0d.wrap_p", k), wp, m_wp[k]);
        end
    endtask

    task automatic cyc(input bit r, input bit ld, input bit sp, input bit st,
                       input bit tk, input bit d, input int lm, input int ls);
        rst = r; load = ld; stop = sp; start = st; tick = tk; dir = d;
        load_min = 6'(lm); load_sec = 6'(ls);
        @(posedge clk);
        model_step(r, ld, sp, st, tk, d, lm, ls);
        #1;
        check_all();
    endtask

    initial begin
        int carry_cnt, carry_at, keep_m, keep_s;

        // reset and 61 up-ticks
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset.min", int'(min0), 0);
        chk("reset.sec", int'(sec0), 0);
        chk("reset.running", int'(run0), 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        carry_cnt = 0;
        carry_at  = -1;
        for (int i = 1; i <= 61; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 0, 0);
            if (cy0) begin carry_cnt++; carry_at = i; end
        end
        chk("run61.min", int'(min0), 1);
        chk("run61.sec", int'(sec0), 1);
        chk("run61.running", int'(run0), 1);
        chk("run61.carry_count", carry_cnt, 1);
        chk("run61.carry_tick", carry_at, 60);

        // up wrap / up terminal
        cyc(0, 1, 0, 0, 0, 0, 59, 58);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("upwrap.t1.sec", int'(sec0), 59);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("upwrap.min", int'(min0), 0);
        chk("upwrap.sec", int'(sec0), 0);
        chk("upwrap.wrap_p", int'(wp0), 1);
        chk("upwrap.carry", int'(cy0), 1);
        chk("upterm.sec", int'(sec1), 59);
        chk("upterm.done", int'(done1), 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("upwrap.wrap_p_clear", int'(wp0), 0);

        // down terminal, WRAP=0
        cyc(0, 1, 0, 0, 0, 1, 0, 2);
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        chk("dnterm.t1.sec", int'(sec1), 1);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        chk("dnterm.t2.sec", int'(sec1), 0);
        chk("dnterm.t2.done", int'(done1), 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        chk("dnterm.t3.done", int'(done1), 1);
        chk("dnterm.t3.wrap_p", int'(wp1), 1);
        chk("dnterm.t3.carry", int'(cy1), 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        chk("dnterm.hold.sec", int'(sec1), 0);
        chk("dnterm.hold.wrap_p", int'(wp1), 0);

        // down borrow and clamp, small fields
        cyc(0, 1, 0, 0, 0, 1, 2, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 0, 0);
        chk("borrow.min", int'(min2), 1);
        chk("borrow.sec", int'(sec2), 9);
        chk("borrow.carry", int'(cy2), 1);
        cyc(0, 1, 0, 0, 0, 1, 7, 12);
        chk("clamp.min", int'(min2), 3);
        chk("clamp.sec", int'(sec2), 9);

        // control priority
        keep_m = int'(min0);
        keep_s = int'(sec0);
        cyc(0, 0, 1, 1, 1, 0, 0, 0);
        chk("prio.stop.running", int'(run0), 0);
        chk("prio.stop.min", int'(min0), keep_m);
        chk("prio.stop.sec", int'(sec0), keep_s);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0, 10, 10);
        chk("prio.load.min", int'(min0), 10);
        chk("prio.load.sec", int'(sec0), 10);
        chk("prio.load.running", int'(run0), 1);

        // zero-start in down mode
        cyc(0, 0, 1, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0);
        chk("zstart.done", int'(done1), 1);
        chk("zstart.wrap_p", int'(wp1), 1);
        chk("zstart.running", int'(run1), 0);

        // mid-run reset
        cyc(0, 1, 0, 0, 0, 0, 12, 34);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("midrst.pre.min", int'(min0), 12);
        chk("midrst.pre.running", int'(run0), 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("midrst.min", int'(min0), 0);
        chk("midrst.sec", int'(sec0), 0);
        chk("midrst.running", int'(run0), 0);

        // randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            bit r, ld, sp, st, tk, d;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 19) == 0);
            sp = ($urandom_range(0, 24) == 0);
            st = ($urandom_range(0, 9) == 0);
            tk = ($urandom_range(0, 1) == 1);
            d  = (($urandom_range(0, 15) == 0) ? ~dir : dir);
            cyc(r, ld, sp, st, tk, d, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
